// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the fetch queue front end.
package fetch_queue_unit_pkg;

    localparam int unsigned PC_INCR         = 4;
    localparam int unsigned DEFAULT_PC_W    = 32;
    localparam int unsigned DEFAULT_INSTR_W = 32;

    // Default queue entry; the top level redeclares it at its own widths.
    typedef struct packed {
        logic [DEFAULT_PC_W-1:0]    pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// I-cache request/response and decode-side handshake bundle for fetch_queue_unit.
interface fetch_queue_unit_if
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned PC_W        = DEFAULT_PC_W,
    parameter int unsigned INSTR_W     = DEFAULT_INSTR_W,
    parameter int unsigned QUEUE_DEPTH = 4
);
    localparam int unsigned OCC_W = $clog2(QUEUE_DEPTH + 1);

    logic               take_branch;
    logic [PC_W-1:0]    branch_loc;
    logic               icache_req_valid;
    logic               icache_req_ready;
    logic [PC_W-1:0]    icache_req_pc;
    logic               icache_resp_valid;
    logic [INSTR_W-1:0] icache_resp_instr;
    logic [INSTR_W-1:0] instr_to_decode;
    logic [PC_W-1:0]    pc_to_decode;
    logic               valid;
    logic               ready;
    logic [OCC_W-1:0]   occupancy;

    modport master (
        input  take_branch, branch_loc, icache_req_ready,
        input  icache_resp_valid, icache_resp_instr, ready,
        output icache_req_valid, icache_req_pc,
        output instr_to_decode, pc_to_decode, valid, occupancy
    );

    modport slave (
        output take_branch, branch_loc, icache_req_ready,
        output icache_resp_valid, icache_resp_instr, ready,
        input  icache_req_valid, icache_req_pc,
        input  instr_to_decode, pc_to_decode, valid, occupancy
    );

endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous instruction queue with flush; head holds its last shown value while empty.
module fetch_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter type         T     = fetch_entry_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    output T                           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T                mem [DEPTH];
    T                held;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            held   <= '0;
        end else begin
            held <= head;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Full-queue push+pop writes the slot being read; the read sees the old entry.
    assign head = (count != '0) ? mem[rd_ptr] : held;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: credit-limited I-cache requests, in-order responses, instruction queue, redirect flush.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned     PC_W            = DEFAULT_PC_W,
    parameter int unsigned     INSTR_W         = DEFAULT_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC        = '0,
    parameter int unsigned     QUEUE_DEPTH     = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               reset,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned OCC_W = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  resp_pc;
    logic [PC_W-1:0]  branch_pc;
    logic [OW-1:0]    outstanding;
    logic [OW-1:0]    outstanding_nxt;
    logic [OW-1:0]    drop_cnt;
    logic [OCC_W-1:0] count;
    logic             credit_ok;
    logic             req_valid;
    logic             fire;
    logic             push;
    logic             pop;
    entry_t           push_entry;
    entry_t           head;

    assign branch_pc = bus.branch_loc & ~PC_W'(3);

    always_comb begin
        credit_ok = (outstanding < OW'(MAX_OUTSTANDING))
                 && ((32'(outstanding) + 32'(count)) < QUEUE_DEPTH);
        req_valid = reset && !bus.take_branch && credit_ok;
        fire      = req_valid && bus.icache_req_ready;
        outstanding_nxt = outstanding + OW'(fire) - OW'(bus.icache_resp_valid);
        push      = bus.icache_resp_valid && !bus.take_branch && (drop_cnt == '0);
        pop       = (count != '0) && bus.ready && !bus.take_branch;
        push_entry.pc    = resp_pc;
        push_entry.instr = bus.icache_resp_instr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (bus.take_branch) begin
                fetch_pc <= branch_pc;
                resp_pc  <= branch_pc;
                // Every request still in flight after this edge is stale, including
                // any left over from an earlier redirect, so this is remaining + new.
                drop_cnt <= outstanding_nxt;
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + PC_W'(PC_INCR);
                end
                if (bus.icache_resp_valid) begin
                    if (drop_cnt != '0) begin
                        drop_cnt <= drop_cnt - OW'(1);
                    end else begin
                        resp_pc <= resp_pc + PC_W'(PC_INCR);
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (bus.take_branch),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign bus.icache_req_valid = req_valid;
    assign bus.icache_req_pc    = fetch_pc;
    assign bus.instr_to_decode  = head.instr;
    assign bus.pc_to_decode     = head.pc;
    assign bus.valid            = (count != '0);
    assign bus.occupancy        = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a fixed-latency cache model and a decode-side scoreboard.
module tb_fetch_queue_unit;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int first_fire  = -1;
    int deq_count   = 0;
    int stale_cnt   = 0;

    logic [31:0] next_pc;
    logic [31:0] last_deq_pc;
    logic [31:0] exp_q[$];
    logic [31:0] infl_pc[$];
    int          infl_due[$];

    always #5 clk = ~clk;

    fetch_queue_unit_if #(.PC_W(32), .INSTR_W(32), .QUEUE_DEPTH(4)) bus();

    fetch_queue_unit #(
        .PC_W            (32),
        .INSTR_W         (32),
        .RESET_PC        (32'h100),
        .QUEUE_DEPTH     (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hC3A5, ~pc[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        infl_pc.delete();
        infl_due.delete();
        stale_cnt  = 0;
        cyc        = 0;
        first_fire = -1;
        next_pc    = 32'h100;
    endtask

    // One clock cycle: sample settled outputs, update the cache model and scoreboard, advance.
    task automatic tick();
        logic        fire;
        logic        deq;
        logic [31:0] req;
        logic [31:0] rpc;
        logic [31:0] epc;
        #1;
        req  = next_pc;
        fire = bus.icache_req_valid && bus.icache_req_ready;
        chk("occupancy", 32'(bus.occupancy), 32'(exp_q.size()));
        chk("valid", 32'(bus.valid), 32'(exp_q.size() != 0));
        if (fire) begin
            chk("req_pc", bus.icache_req_pc, req);
            if (first_fire < 0) first_fire = cyc;
        end
        deq = bus.valid && bus.ready && !bus.take_branch;
        if (deq && exp_q.size() != 0) begin
            epc = exp_q.pop_front();
            chk("deq_pc", bus.pc_to_decode, epc);
            chk("deq_instr", bus.instr_to_decode, instr_of(epc));
            last_deq_pc = bus.pc_to_decode;
            deq_count++;
        end
        if (bus.icache_resp_valid && infl_pc.size() != 0) begin
            rpc = infl_pc.pop_front();
            void'(infl_due.pop_front());
            if (stale_cnt > 0) stale_cnt--;
            else if (!bus.take_branch) exp_q.push_back(rpc);
        end
        if (bus.take_branch) begin
            exp_q.delete();
            stale_cnt = infl_pc.size();
            next_pc   = bus.branch_loc & ~32'h3;
        end
        if (fire) begin
            infl_pc.push_back(req);
            infl_due.push_back(cyc + LAT);
            if (bus.take_branch) stale_cnt++;
            else next_pc = next_pc + 32'd4;
        end
        @(negedge clk);
        cyc++;
        bus.icache_resp_valid = (infl_pc.size() != 0) && (infl_due[0] <= cyc);
        bus.icache_resp_instr = bus.icache_resp_valid ? instr_of(infl_pc[0]) : '0;
    endtask

    // Reset asserted between clock edges, then released on the next falling edge.
    task automatic do_reset();
        #3;
        reset = 1'b0;
        bus.icache_resp_valid = 1'b0;
        bus.take_branch = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_req_valid", 32'(bus.icache_req_valid), 32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        clear_model();
    endtask

    task automatic wait_deq(input string tag, input logic [31:0] expv);
        int d0;
        d0 = deq_count;
        last_deq_pc = 32'hDEAD_BEEF;
        for (int n = 0; n < 30; n++) begin
            if (deq_count != d0) break;
            tick();
        end
        chk(tag, last_deq_pc, expv);
    endtask

    task automatic drain();
        bus.ready = 1'b1;
        bus.icache_req_ready = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (infl_pc.size() == 0 && exp_q.size() == 0) break;
            tick();
        end
        chk("drain_empty", 32'(exp_q.size() + infl_pc.size()), 32'd0);
        tick();
        bus.icache_req_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        reset = 1'b0;
        bus.take_branch       = 1'b0;
        bus.branch_loc        = '0;
        bus.icache_req_ready  = 1'b1;
        bus.icache_resp_valid = 1'b0;
        bus.icache_resp_instr = '0;
        bus.ready             = 1'b1;
        last_deq_pc           = '0;
        clear_model();
        @(negedge clk);
        #1;
        chk("init_valid", 32'(bus.valid), 32'd0);
        chk("init_req_valid", 32'(bus.icache_req_valid), 32'd0);
        chk("init_occupancy", 32'(bus.occupancy), 32'd0);
        chk("init_instr", bus.instr_to_decode, 32'd0);
        chk("init_pc", bus.pc_to_decode, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        clear_model();

        // 1: streaming fetch from RESET_PC, first head four cycles after first fire
        for (int n = 0; n < 20; n++) begin
            if (bus.valid) break;
            tick();
        end
        chk("t1_first_valid_latency", 32'(cyc - first_fire), 32'd4);
        repeat (12) tick();
        drain();

        // 2: decode stalled, queue fills to depth, then drains in order
        do_reset();
        bus.ready = 1'b0;
        repeat (12) tick();
        chk("t2_occupancy_full", 32'(bus.occupancy), 32'd4);
        chk("t2_req_blocked", 32'(bus.icache_req_valid), 32'd0);
        bus.ready = 1'b1;
        wait_deq("t2_first_drained_pc", 32'h100);
        drain();

        // 3: redirect with two requests in flight to an unaligned target
        do_reset();
        bus.ready = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (infl_pc.size() == 2 && exp_q.size() != 0) break;
            tick();
        end
        chk("t3_setup_valid", 32'(bus.valid), 32'd1);
        bus.take_branch = 1'b1;
        bus.branch_loc  = 32'h203;
        tick();
        bus.take_branch = 1'b0;
        chk("t3_valid_after_redirect", 32'(bus.valid), 32'd0);
        bus.ready = 1'b1;
        wait_deq("t3_first_pc_after_redirect", 32'h200);
        drain();

        // 4: redirect coinciding with a response and a dequeue
        do_reset();
        bus.ready = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (exp_q.size() >= 2) break;
            tick();
        end
        bus.ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (bus.icache_resp_valid && bus.valid) break;
            tick();
        end
        chk("t4_setup_resp_and_deq", 32'(bus.icache_resp_valid && bus.valid), 32'd1);
        bus.take_branch = 1'b1;
        bus.branch_loc  = 32'h300;
        tick();
        bus.take_branch = 1'b0;
        chk("t4_occupancy_flushed", 32'(bus.occupancy), 32'd0);
        wait_deq("t4_first_pc_after_redirect", 32'h300);
        drain();

        // 5: cache not ready, request PC held
        do_reset();
        bus.ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (next_pc == 32'h108) break;
            tick();
        end
        bus.icache_req_ready = 1'b0;
        repeat (5) begin
            chk("t5_req_pc_held", bus.icache_req_pc, 32'h108);
            tick();
        end
        bus.icache_req_ready = 1'b1;
        chk("t5_resume_pc", bus.icache_req_pc, 32'h108);
        repeat (6) tick();
        drain();

        // 6: asynchronous reset mid-stream, fetch restarts at RESET_PC
        do_reset();
        bus.ready = 1'b0;
        repeat (6) tick();
        chk("t6_pre_reset_valid", 32'(bus.valid), 32'd1);
        do_reset();
        #1;
        chk("t6_restart_pc", bus.icache_req_pc, 32'h100);
        chk("t6_restart_req_valid", 32'(bus.icache_req_valid), 32'd1);
        bus.ready = 1'b1;
        repeat (8) tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
